imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Host-side writer for the instruction memory's la_instruction_* port. Accepts a byte stream
//  (valid/ready), assembles little-endian 32-bit words and writes them to consecutive IMEM slots.
//  Verifies each word through la_instruction_read and holds the CPU core in reset while loading.
// PARAMETERS
//  NUM_SLOTS       16    IMEM word slots; select width is clog2(NUM_SLOTS)=4
//  TIMEOUT_CYCLES  1024  max idle cycles waiting for a byte in RECV; 0 disables timeout
// PORTS
//  clk                    in   1   clock
//  rst_n                  in   1   reset, asynchronous, active-low
//  start                  in   1   1-cycle pulse: begin load; ignored while busy
//  num_words              in   5   words to load, latched on start; legal 0..16
//  byte_in                in   8   stream data
//  byte_valid             in   1   stream data valid
//  byte_ready             out  1   loader accepts byte (transfer = valid & ready)
//  la_instruction_input   out  32  word to write
//  la_instruction_select  out  4   target slot
//  la_instruction_write   out  1   write strobe, one cycle per word
//  la_instruction_read    in   32  combinational readback of the selected slot
//  core_rst_n             out  1   active-low reset to CPU core (PC/regfile); never drives IMEM rst_n
//  busy                   out  1   high in RECV/WRITE/VERIFY
//  done                   out  1   high in DONE until next start
//  error                  out  1   high in ERR until next start
//  error_code             out  2   00 none, 01 bad length, 10 verify mismatch, 11 timeout
//  words_loaded           out  5   count of words written and verified
// BEHAVIOUR
//  Reset: state IDLE; byte_ready=0, la_instruction_write=0, la_instruction_input=0, select=0,
//   core_rst_n=0, busy=done=error=0, error_code=00, words_loaded=0. Async: a write strobe drops
//   immediately; partial word and counts are discarded.
//  core_rst_n=1 only in IDLE-after-first-DONE and DONE; 0 in reset, IDLE before first load,
//   RECV, WRITE, VERIFY and ERR.
//  IDLE/DONE/ERR --start--> num_words>16: ERR(01); num_words==0: DONE next cycle, words_loaded=0;
//   else RECV with slot=0, byte_idx=0, words_loaded=0, timeout counter=0, done=error=0.
//  RECV: byte_ready=1. Each transfer stores byte_in at word[8*byte_idx+:8], byte_idx++,
//   timeout counter cleared. On the 4th transfer go to WRITE next cycle. Cycles without a transfer
//   increment the counter; counter==TIMEOUT_CYCLES-1 with no transfer -> ERR(11).
//  WRITE (1 cycle): byte_ready=0, write=1, select=slot, input=word. IMEM captures at the next edge.
//  VERIFY (1 cycle): write=0, select=slot held; compare la_instruction_read to word.
//   Mismatch -> ERR(10), words_loaded unchanged. Match: words_loaded++; if words_loaded+1==num_words
//   -> DONE, else slot++, byte_idx=0, -> RECV.
//  Minimum cost per word: 4 transfer cycles + 2 = 6 cycles. select never exceeds NUM_SLOTS-1.
//  la_instruction_input/select hold last values outside WRITE/VERIFY; write only in WRITE.
//  byte_valid while byte_ready=0 is not consumed (stream must hold its byte).
//  start during busy: ignored, no state change. start coincident with ERR/DONE entry: ignored.
//  words_loaded is 5 bits so 16 is representable; no wrap.
// STRUCTURE
//  imem_loader_defs.vh: state encodings (IDLE,RECV,WRITE,VERIFY,DONE,ERR), error_code values,
//   byte-index width. Included by loader RTL and bench.
//  Sub-module imem_word_assembler: byte_idx counter + 32-bit shift/insert register with clear and
//   word_full flag. The FSM, slot counter and timeout counter stay in imem_loader.
// TESTING (bench includes real IMEM model wired to la_instruction_*)
//  Load 2 words, bytes 13,00,C0,03 / 93,00,10,00 back-to-back -> slot0=03C00013, slot1=00100093,
//   two write pulses, done=1, words_loaded=2, core_rst_n rises the cycle DONE is entered.
//  Load 16 words with random byte_valid gaps <TIMEOUT -> all slots match, select 0..15, no error.
//  num_words=17 -> error=1, error_code=01, no write pulse; num_words=0 -> done, words_loaded=0.
//  Force readback bit flip on word 3 -> ERR(10), words_loaded=3, core_rst_n stays 0.
//  Stop stream after 2 bytes, TIMEOUT_CYCLES=8 -> ERR(11) exactly 8 idle cycles later.
//  Assert rst_n low during WRITE -> write drops asynchronously, all outputs at reset values;
//   start pulse while busy -> no effect on slot/count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BAD_LEN = 2'b01,
        ERR_VERIFY  = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full_c,
    output logic [WORD_W-1:0] word_next_c
);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [WORD_W-1:0]     word_q;

    // Word value including the byte being accepted this cycle.
    always_comb begin
        word_next_c = word_q;
        if (load) begin
            word_next_c[{idx_q, 3'b000} +: BYTE_W] = byte_in;
        end
    end

    assign word_full_c = load && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word        = word_q;

    // Byte index and word storage; index wraps to 0 after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load) begin
            idx_q  <= idx_q + BYTE_IDX_W'(1);
            word_q <= word_next_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into IMEM word slots, verifies each write, holds the core in reset while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [$clog2(NUM_SLOTS+1)-1:0]     num_words,
    input  logic [BYTE_W-1:0]                  byte_in,
    input  logic                               byte_valid,
    output logic                               byte_ready,
    output logic [WORD_W-1:0]                  la_instruction_input,
    output logic [$clog2(NUM_SLOTS)-1:0]       la_instruction_select,
    output logic                               la_instruction_write,
    input  logic [WORD_W-1:0]                  la_instruction_read,
    output logic                               core_rst_n,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [1:0]                         error_code,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     words_loaded
);

    localparam int unsigned SEL_W = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [WORD_W-1:0] input_q, input_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    err_code_t         code_q, code_d;
    logic              write_q, ready_q, busy_q, done_q, error_q, core_q;
    logic              write_d, ready_d, busy_d, done_d, error_d, core_d;

    logic              xfer;
    logic              asm_clear;
    logic [WORD_W-1:0] asm_word;
    logic              asm_full_c;
    logic [WORD_W-1:0] asm_next_c;

    assign xfer = byte_valid & ready_q;

    imem_word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (asm_clear),
        .load        (xfer),
        .byte_in     (byte_in),
        .word        (asm_word),
        .word_full_c (asm_full_c),
        .word_next_c (asm_next_c)
    );

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        num_d     = num_q;
        words_d   = words_q;
        to_d      = to_q;
        input_d   = input_q;
        sel_d     = sel_q;
        code_d    = code_q;
        asm_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    code_d  = ERR_NONE;
                    words_d = '0;
                    num_d   = num_words;
                    if (num_words > CNT_W'(NUM_SLOTS)) begin
                        state_d = ST_ERR;
                        code_d  = ERR_BAD_LEN;
                    end else if (num_words == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RECV;
                        slot_d    = '0;
                        to_d      = '0;
                        asm_clear = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (xfer) begin
                    to_d = '0;
                    if (asm_full_c) begin
                        state_d = ST_WRITE;
                        input_d = asm_next_c;
                        sel_d   = slot_q;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ST_ERR;
                        code_d  = ERR_TIMEOUT;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (la_instruction_read != asm_word) begin
                    state_d = ST_ERR;
                    code_d  = ERR_VERIFY;
                end else begin
                    words_d = words_q + CNT_W'(1);
                    if ((words_q + CNT_W'(1)) == num_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RECV;
                        slot_d    = slot_q + SEL_W'(1);
                        to_d      = '0;
                        asm_clear = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        write_d = (state_d == ST_WRITE);
        ready_d = (state_d == ST_RECV);
        busy_d  = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_VERIFY);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
        core_d  = (state_d == ST_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            num_q   <= '0;
            words_q <= '0;
            to_q    <= '0;
            input_q <= '0;
            sel_q   <= '0;
            code_q  <= ERR_NONE;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            core_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            num_q   <= num_d;
            words_q <= words_d;
            to_q    <= to_d;
            input_q <= input_d;
            sel_q   <= sel_d;
            code_q  <= code_d;
            write_q <= write_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            core_q  <= core_d;
        end
    end

    assign byte_ready            = ready_q;
    assign la_instruction_input  = input_q;
    assign la_instruction_select = sel_q;
    assign la_instruction_write  = write_q;
    assign core_rst_n            = core_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign error                 = error_q;
    assign error_code            = code_q;
    assign words_loaded          = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with an IMEM model on the la_instruction_* port.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_words = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] la_instruction_input;
    logic [3:0]  la_instruction_select;
    logic        la_instruction_write;
    logic [31:0] la_instruction_read;
    logic        core_rst_n, busy, done, error;
    logic [1:0]  error_code;
    logic [4:0]  words_loaded;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          wr_count = 0;
    logic        flip_en = 1'b0;
    logic [31:0] imem [16];
    logic [31:0] words [16];
    wr_t         exp_q [$];

    imem_loader #(.NUM_SLOTS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .num_words             (num_words),
        .byte_in               (byte_in),
        .byte_valid            (byte_valid),
        .byte_ready            (byte_ready),
        .la_instruction_input  (la_instruction_input),
        .la_instruction_select (la_instruction_select),
        .la_instruction_write  (la_instruction_write),
        .la_instruction_read   (la_instruction_read),
        .core_rst_n            (core_rst_n),
        .busy                  (busy),
        .done                  (done),
        .error                 (error),
        .error_code            (error_code),
        .words_loaded          (words_loaded)
    );

    always #5 clk = ~clk;

    // IMEM model: synchronous write, combinational read with optional bit-7 corruption on slot 3.
    always @(posedge clk) begin
        if (la_instruction_write === 1'b1) begin
            imem[la_instruction_select] <= la_instruction_input;
            wr_count <= wr_count + 1;
        end
    end
    assign la_instruction_read = imem[la_instruction_select] ^
        ((flip_en && la_instruction_select == 4'd3) ? 32'h0000_0080 : 32'h0);

    task automatic pulse_start(input logic [4:0] n);
        @(negedge clk);
        num_words = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int n = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (byte_ready === 1'b1);
        if (ok) @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic drive_words(input int n, input int max_gap);
        bit          ok;
        logic [31:0] w32;
        for (int w = 0; w < n; w++) begin
            w32 = words[w];
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back({4'(w), w32});
                send_byte(8'(w32 >> (8 * k)), (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)), ok);
                if (!ok) return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({byte_ready, la_instruction_write, core_rst_n, busy, done, error} !== 6'b0)
            $display("FAIL reset_ctl: got %b expected 000000", {byte_ready, la_instruction_write, core_rst_n, busy, done, error});
        else pass_cnt++;
        chk_cnt++;
        if (la_instruction_input !== 32'h0) $display("FAIL reset_input: got %h expected 0", la_instruction_input);
        else pass_cnt++;
        chk_cnt++;
        if (la_instruction_select !== 4'h0) $display("FAIL reset_select: got %0d expected 0", la_instruction_select);
        else pass_cnt++;
        chk_cnt++;
        if ({error_code, words_loaded} !== 7'h0) $display("FAIL reset_code_count: got %b/%0d expected 00/0", error_code, words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_two_words();
        int   seen = 0, cyc = 0, w0;
        logic core_prev;
        wr_t  e;
        time  t0;
        exp_q.delete();
        words[0] = 32'h03C00013;
        words[1] = 32'h00100093;
        w0 = wr_count;
        pulse_start(5'd2);
        t0 = $time;
        fork
            drive_words(2, 0);
            begin
                while (seen < 2 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (la_instruction_write === 1'b1) begin
                        seen++;
                        chk_cnt++;
                        if (exp_q.size() == 0) $display("FAIL two_sb: unexpected write sel=%0d data=%h", la_instruction_select, la_instruction_input);
                        else begin
                            e = exp_q.pop_front();
                            if ({la_instruction_select, la_instruction_input} !== e)
                                $display("FAIL two_sb: got sel=%0d data=%h expected sel=%0d data=%h", la_instruction_select, la_instruction_input, e.sel, e.data);
                            else pass_cnt++;
                        end
                    end
                end
            end
        join
        cyc = 0;
        core_prev = core_rst_n;
        while (done !== 1'b1 && cyc < 20) begin
            core_prev = core_rst_n;
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (done !== 1'b1 || ($time - t0) !== 120) $display("FAIL two_done: done=%b after %0t expected 1 after 120", done, $time - t0);
        else pass_cnt++;
        chk_cnt++;
        if (core_prev !== 1'b0 || core_rst_n !== 1'b1) $display("FAIL two_core_rst: before=%b at_done=%b expected 0 then 1", core_prev, core_rst_n);
        else pass_cnt++;
        chk_cnt++;
        if (words_loaded !== 5'd2) $display("FAIL two_count: got %0d expected 2", words_loaded);
        else pass_cnt++;
        chk_cnt++;
        if (imem[0] !== 32'h03C00013 || imem[1] !== 32'h00100093)
            $display("FAIL two_imem: got %h %h expected 03c00013 00100093", imem[0], imem[1]);
        else pass_cnt++;
        chk_cnt++;
        if (wr_count - w0 !== 2) $display("FAIL two_pulses: got %0d expected 2", wr_count - w0);
        else pass_cnt++;
    endtask

    task automatic test_sixteen();
        int  seen = 0, cyc = 0, bad = 0;
        wr_t e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        pulse_start(5'd16);
        fork
            drive_words(16, 5);
            begin
                while (seen < 16 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (la_instruction_write === 1'b1) begin
                        seen++;
                        chk_cnt++;
                        if (exp_q.size() == 0) $display("FAIL sixteen_sb: unexpected write sel=%0d", la_instruction_select);
                        else begin
                            e = exp_q.pop_front();
                            if ({la_instruction_select, la_instruction_input} !== e)
                                $display("FAIL sixteen_sb: got sel=%0d data=%h expected sel=%0d data=%h", la_instruction_select, la_instruction_input, e.sel, e.data);
                            else pass_cnt++;
                        end
                    end
                end
            end
        join
        cyc = 0;
        while (done !== 1'b1 && error !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 5'd16)
            $display("FAIL sixteen_done: done=%b error=%b count=%0d expected 1/0/16", done, error, words_loaded);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) if (imem[i] !== words[i]) bad++;
        chk_cnt++;
        if (bad !== 0) $display("FAIL sixteen_imem: %0d slots differ expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_bad_len();
        int w0 = wr_count;
        pulse_start(5'd17);
        chk_cnt++;
        if (error !== 1'b1 || error_code !== 2'b01 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL bad_len: error=%b code=%b done=%b busy=%b expected 1/01/0/0", error, error_code, done, busy);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wr_count !== w0) $display("FAIL bad_len_write: got %0d pulses expected 0", wr_count - w0);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        pulse_start(5'd0);
        chk_cnt++;
        if (done !== 1'b1 || error !== 1'b0 || error_code !== 2'b00 || words_loaded !== 5'd0 || core_rst_n !== 1'b1)
            $display("FAIL zero_len: done=%b error=%b code=%b count=%0d core=%b expected 1/0/00/0/1",
                     done, error, error_code, words_loaded, core_rst_n);
        else pass_cnt++;
    endtask

    task automatic test_verify_fail();
        int  seen = 0, cyc = 0;
        wr_t e;
        exp_q.delete();
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        flip_en = 1'b1;
        pulse_start(5'd5);
        fork
            drive_words(5, 2);
            begin
                while (seen < 4 && cyc < 500) begin
                    @(negedge clk);
                    cyc++;
                    if (la_instruction_write === 1'b1) begin
                        seen++;
                        chk_cnt++;
                        if (exp_q.size() == 0) $display("FAIL verify_sb: unexpected write sel=%0d", la_instruction_select);
                        else begin
                            e = exp_q.pop_front();
                            if ({la_instruction_select, la_instruction_input} !== e)
                                $display("FAIL verify_sb: got sel=%0d data=%h expected sel=%0d data=%h", la_instruction_select, la_instruction_input, e.sel, e.data);
                            else pass_cnt++;
                        end
                    end
                end
            end
        join
        cyc = 0;
        while (error !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        flip_en = 1'b0;
        chk_cnt++;
        if (error !== 1'b1 || error_code !== 2'b10) $display("FAIL verify_err: error=%b code=%b expected 1/10", error, error_code);
        else pass_cnt++;
        chk_cnt++;
        if (words_loaded !== 5'd3 || core_rst_n !== 1'b0 || done !== 1'b0)
            $display("FAIL verify_state: count=%0d core=%b done=%b expected 3/0/0", words_loaded, core_rst_n, done);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        int k = 0;
        pulse_start(5'd2);
        send_byte(8'hAA, 0, ok1);
        send_byte(8'hBB, 0, ok2);
        while (error !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk_cnt++;
        if (!ok1 || !ok2 || k !== 8) $display("FAIL timeout_cycles: got %0d idle cycles (accepted %b%b) expected 8", k, ok1, ok2);
        else pass_cnt++;
        chk_cnt++;
        if (error_code !== 2'b11 || busy !== 1'b0 || byte_ready !== 1'b0)
            $display("FAIL timeout_state: code=%b busy=%b ready=%b expected 11/0/0", error_code, busy, byte_ready);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        bit          ok = 1'b1;
        int          cyc = 0;
        logic [31:0] w32;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        pulse_start(5'd3);
        for (int w = 0; w < 3; w++) begin
            w32 = words[w];
            for (int k = 0; k < 4; k++) begin
                if (w == 1 && k == 2) begin
                    num_words = 5'd1;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (ok) send_byte(8'(w32 >> (8 * k)), 0, ok);
            end
        end
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (!ok || done !== 1'b1 || words_loaded !== 5'd3 || la_instruction_select !== 4'd2)
            $display("FAIL busy_start: ok=%b done=%b count=%0d sel=%0d expected 1/1/3/2", ok, done, words_loaded, la_instruction_select);
        else pass_cnt++;
        chk_cnt++;
        if (imem[0] !== words[0] || imem[1] !== words[1] || imem[2] !== words[2])
            $display("FAIL busy_start_imem: got %h %h %h expected %h %h %h", imem[0], imem[1], imem[2], words[0], words[1], words[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_during_write();
        bit          ok = 1'b1;
        logic [31:0] snap = imem[0];
        logic [31:0] w32 = ~snap;
        pulse_start(5'd1);
        for (int k = 0; k < 4; k++) if (ok) send_byte(8'(w32 >> (8 * k)), 0, ok);
        chk_cnt++;
        if (la_instruction_write !== 1'b1 || la_instruction_input !== w32 || la_instruction_select !== 4'd0)
            $display("FAIL rst_write_pre: write=%b data=%h sel=%0d expected 1/%h/0", la_instruction_write, la_instruction_input, la_instruction_select, w32);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({byte_ready, la_instruction_write, core_rst_n, busy, done, error} !== 6'b0 ||
            la_instruction_input !== 32'h0 || la_instruction_select !== 4'h0 || {error_code, words_loaded} !== 7'h0)
            $display("FAIL rst_async: ctl=%b data=%h sel=%0d code=%b count=%0d expected all zero",
                     {byte_ready, la_instruction_write, core_rst_n, busy, done, error},
                     la_instruction_input, la_instruction_select, error_code, words_loaded);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (imem[0] !== snap || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_no_write: slot0=%h done=%b busy=%b expected %h/0/0", imem[0], done, busy, snap);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_sixteen();
        test_bad_len();
        test_zero_len();
        test_verify_fail();
        test_timeout();
        test_start_while_busy();
        test_reset_during_write();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
